pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage 8-bit pipeline: IF, IF_ID, ID_EXE, EXE_MEM, MEM_WB.
- Drives the write-enables and clear strobes of the PC and the pipeline registers.
- Handles load-use hazards (multi-cycle stall), taken-branch flushes and data-memory wait freezes.
- Keeps saturating stall and flush event counters for debug.

Parameters:
LOAD_STALL, 1, bubbles inserted per load-use hazard (1..7).
CNT_W, 16, width of the stall and flush counters.

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
id_rs  in  3  source register 1 of the instruction in ID
id_rt  in  3  source register 2 of the instruction in ID
id_use_rs  in  1  ID instruction reads id_rs
id_use_rt  in  1  ID instruction reads id_rt
exe_memRd  in  1  instruction in EXE is a load
exe_regWr  in  1  instruction in EXE writes a register
exe_rd  in  3  destination register of the instruction in EXE
br_taken  in  1  branch/jump resolved taken in EXE this cycle
mem_busy  in  1  data memory not ready; level-sensitive
cnt_clr  in  1  synchronous clear of both counters
pc_en  out  1  PC load enable
if_id_en  out  1  IF_ID register enable
if_id_flush  out  1  IF_ID clears to NOP at next edge
id_exe_en  out  1  ID_EXE register enable
id_exe_bubble  out  1  ID_EXE loads zero control fields: regWr, memRd, memWr, cWr, zWr, aluOp
exe_mem_en  out  1  EXE_MEM and MEM_WB register enable
state  out  2  FSM state: RUN=0, LU_STALL=1, MEM_WAIT=2, FLUSH_PEND=3
stall_cnt  out  CNT_W  cycles with pc_en=0, saturating
flush_cnt  out  CNT_W  cycles with if_id_flush=1, saturating

Behaviour:
- Reset (async, rst=1): state=RUN, stall counter=0, pending flag=0, stall_cnt=0, flush_cnt=0. While rst is high, all enables, if_id_flush and id_exe_bubble are 0.
- Outputs are combinational from state and inputs (Mealy). Registers update on posedge clk.
- Hazard term: lu = exe_memRd & exe_regWr & ((id_use_rs & id_rs==exe_rd) | (id_use_rt & id_rt==exe_rd)). Register 0 gets no exemption.
- Priority, highest first: mem_busy, then br_taken or pending flush, then lu or LU_STALL, then normal run.
- Normal (RUN, no event): all enables=1; flush=0; bubble=0.
- mem_busy=1, any state:
  - all enables=0, flush=0, bubble=0.
  - next state MEM_WAIT.
  - If br_taken=1 in this cycle, set pending=1.
  - Stall counter value is held.
- MEM_WAIT with mem_busy=0:
  - If pending=1: apply the flush this cycle, clear pending, go to RUN.
  - Else if the stall counter is nonzero: resume LU_STALL.
  - Else: go to RUN and evaluate lu this cycle.
- Flush (br_taken=1 or pending=1, mem_busy=0):
  - pc_en=1, if_id_en=1, if_id_flush=1, id_exe_en=1, id_exe_bubble=1, exe_mem_en=1.
  - Clears the stall counter; next state RUN.
  - Flush overrides any load-use stall in progress.
- Load-use (lu=1 in RUN, no higher event):
  - pc_en=0, if_id_en=0, id_exe_en=1, id_exe_bubble=1, exe_mem_en=1.
  - If LOAD_STALL>1: load stall counter with LOAD_STALL-1 and go to LU_STALL. Else stay in RUN (the bubble clears lu next cycle).
- LU_STALL: same outputs as load-use. Decrement the stall counter; when it reaches 0, go to RUN. lu is not re-evaluated in this state.
- Latency: a hazard is resolved in the same cycle it appears. No output is registered.
- Counters:
  - cnt_clr=1 zeroes both counters and takes precedence over increment in the same cycle.
  - Otherwise stall_cnt increments on each cycle with pc_en=0, and flush_cnt on each cycle with if_id_flush=1.
  - Both saturate at all-ones.
- Invariants checked by assertion:
  - if_id_flush=1 implies pc_en=1.
  - id_exe_bubble=1 implies id_exe_en=1.
  - Never pc_en=1 with if_id_en=0.

Decomposition:
- Shared package pipe_pkg holds:
  - state encodings RUN, LU_STALL, MEM_WAIT, FLUSH_PEND;
  - REG_ADDR_W=3, DATA_W=8, PC_W=12.
- One natural sub-module: sat_counter (CNT_W, inc, clr). It is instantiated twice, for stall and flush.

Test Plan:
- Load-use with LOAD_STALL=1: exe_memRd=1, exe_regWr=1, exe_rd=3, id_rs=3, id_use_rs=1 for one cycle -> pc_en=0, if_id_en=0, id_exe_bubble=1 for 1 cycle; stall_cnt=1.
- LOAD_STALL=3, same hazard -> 3 consecutive stall cycles, state 1 for cycles 2-3, then RUN; stall_cnt=3.
- br_taken=1 in the 2nd cycle of a 3-cycle stall -> if_id_flush=1, id_exe_bubble=1, pc_en=1 that cycle, next state RUN; flush_cnt=1, stall_cnt=1.
- mem_busy=1 for 4 cycles, with br_taken pulsed in cycle 2 -> all enables 0 for 4 cycles, state=2; flush applied in cycle 5; stall_cnt=4, flush_cnt=1.
- Async rst asserted mid LU_STALL, between edges -> outputs and counters drop to 0 immediately; state=RUN after release.
- CNT_W=4 with a continuous hazard for 20 cycles -> stall_cnt saturates at 15. cnt_clr together with an increment -> 0.

Source files
------------

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the 5-stage 8-bit pipeline control slice.
package pipe_pkg;

    localparam int REG_ADDR_W = 3;
    localparam int DATA_W     = 8;
    localparam int PC_W       = 12;

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        LU_STALL   = 2'd1,
        MEM_WAIT   = 2'd2,
        FLUSH_PEND = 2'd3
    } hzState_t;

endpackage

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// Debug event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // Clear wins over increment; an increment at all-ones is dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + ONE;
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer: drives PC and pipeline-register enables and clears
// for load-use stalls, taken-branch flushes and data-memory wait freezes.
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int LOAD_STALL = 1,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  id_use_rs,
    input  logic                  id_use_rt,
    input  logic                  exe_memRd,
    input  logic                  exe_regWr,
    input  logic [REG_ADDR_W-1:0] exe_rd,
    input  logic                  br_taken,
    input  logic                  mem_busy,
    input  logic                  cnt_clr,
    output logic                  pc_en,
    output logic                  if_id_en,
    output logic                  if_id_flush,
    output logic                  id_exe_en,
    output logic                  id_exe_bubble,
    output logic                  exe_mem_en,
    output logic [1:0]            state,
    output logic [CNT_W-1:0]      stall_cnt,
    output logic [CNT_W-1:0]      flush_cnt
);

    localparam logic [2:0] LS_RELOAD = 3'(LOAD_STALL - 1);

    hzState_t   curState;
    hzState_t   nextState;
    logic [2:0] luCnt;
    logic [2:0] luCntNext;
    logic       pending;
    logic       pendingNext;
    logic       lu;
    logic       resumeStall;

    assign lu = exe_memRd & exe_regWr &
                ((id_use_rs & (id_rs == exe_rd)) | (id_use_rt & (id_rt == exe_rd)));

    // A stall is still owed if we are in LU_STALL or a memory wait interrupted one.
    assign resumeStall = (curState == LU_STALL) || ((curState == MEM_WAIT) && (luCnt != 3'd0));

    assign state = curState;

    // Priority decode: memory freeze, then flush, then load-use stall, then run.
    always_comb begin
        pc_en         = 1'b1;
        if_id_en      = 1'b1;
        if_id_flush   = 1'b0;
        id_exe_en     = 1'b1;
        id_exe_bubble = 1'b0;
        exe_mem_en    = 1'b1;
        nextState     = RUN;
        luCntNext     = luCnt;
        pendingNext   = pending;
        if (rst) begin
            pc_en      = 1'b0;
            if_id_en   = 1'b0;
            id_exe_en  = 1'b0;
            exe_mem_en = 1'b0;
        end else if (mem_busy) begin
            pc_en      = 1'b0;
            if_id_en   = 1'b0;
            id_exe_en  = 1'b0;
            exe_mem_en = 1'b0;
            nextState  = MEM_WAIT;
            if (br_taken) begin
                pendingNext = 1'b1;
            end
        end else if (br_taken || pending) begin
            if_id_flush   = 1'b1;
            id_exe_bubble = 1'b1;
            luCntNext     = 3'd0;
            pendingNext   = 1'b0;
            nextState     = RUN;
        end else if (resumeStall) begin
            pc_en         = 1'b0;
            if_id_en      = 1'b0;
            id_exe_bubble = 1'b1;
            luCntNext     = (luCnt == 3'd0) ? 3'd0 : luCnt - 3'd1;
            nextState     = (luCnt <= 3'd1) ? RUN : LU_STALL;
        end else if (lu) begin
            pc_en         = 1'b0;
            if_id_en      = 1'b0;
            id_exe_bubble = 1'b1;
            if (LOAD_STALL > 1) begin
                luCntNext = LS_RELOAD;
                nextState = LU_STALL;
            end else begin
                nextState = RUN;
            end
        end else begin
            nextState = RUN;
        end
    end

    // Sequencer state, remaining stall count and deferred-flush flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            curState <= RUN;
            luCnt    <= 3'd0;
            pending  <= 1'b0;
        end else begin
            curState <= nextState;
            luCnt    <= luCntNext;
            pending  <= pendingNext;
        end
    end

    sat_counter #(.CNT_W(CNT_W)) uStallCnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (~pc_en),
        .clr   (cnt_clr),
        .count (stall_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) uFlushCnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (if_id_flush),
        .clr   (cnt_clr),
        .count (flush_cnt)
    );

    flushNeedsPc: assert property (@(posedge clk) disable iff (rst) if_id_flush |-> pc_en);
    bubbleNeedsEn: assert property (@(posedge clk) disable iff (rst) id_exe_bubble |-> id_exe_en);
    pcNeedsIfId: assert property (@(posedge clk) disable iff (rst) pc_en |-> if_id_en);

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed scoreboard bench for pipe_hazard_ctrl. Three instances share the
// stimulus: A (LOAD_STALL=1), B (LOAD_STALL=3), C (LOAD_STALL=1, CNT_W=4).
module tb_pipe_hazard_ctrl;
    import pipe_pkg::*;

    // Output vector order: {pc_en, if_id_en, if_id_flush, id_exe_en, id_exe_bubble, exe_mem_en}
    localparam logic [5:0] NORM  = 6'b110101;
    localparam logic [5:0] STALL = 6'b000111;
    localparam logic [5:0] FLUSH = 6'b111111;
    localparam logic [5:0] FRZ   = 6'b000000;

    localparam int K_OUT   = 0;
    localparam int K_STALL = 1;
    localparam int K_FLUSH = 2;

    typedef struct {
        string       tag;
        int          kind;
        int          sel;
        logic [15:0] val;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [2:0] idRs, idRt, exeRd;
    logic idUseRs, idUseRt, exeMemRd, exeRegWr, brTaken, memBusy, cntClr;

    logic pcEn [3];
    logic ifIdEn [3];
    logic ifIdFlush [3];
    logic idExeEn [3];
    logic idExeBubble [3];
    logic exeMemEn [3];
    logic [1:0] st [3];
    logic [15:0] stallA, flushA, stallB, flushB;
    logic [3:0]  stallC, flushC;

    exp_t sb[$];
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.LOAD_STALL(1), .CNT_W(16)) dutA (
        .clk(clk), .rst(rst), .id_rs(idRs), .id_rt(idRt), .id_use_rs(idUseRs), .id_use_rt(idUseRt),
        .exe_memRd(exeMemRd), .exe_regWr(exeRegWr), .exe_rd(exeRd), .br_taken(brTaken),
        .mem_busy(memBusy), .cnt_clr(cntClr), .pc_en(pcEn[0]), .if_id_en(ifIdEn[0]),
        .if_id_flush(ifIdFlush[0]), .id_exe_en(idExeEn[0]), .id_exe_bubble(idExeBubble[0]),
        .exe_mem_en(exeMemEn[0]), .state(st[0]), .stall_cnt(stallA), .flush_cnt(flushA)
    );

    pipe_hazard_ctrl #(.LOAD_STALL(3), .CNT_W(16)) dutB (
        .clk(clk), .rst(rst), .id_rs(idRs), .id_rt(idRt), .id_use_rs(idUseRs), .id_use_rt(idUseRt),
        .exe_memRd(exeMemRd), .exe_regWr(exeRegWr), .exe_rd(exeRd), .br_taken(brTaken),
        .mem_busy(memBusy), .cnt_clr(cntClr), .pc_en(pcEn[1]), .if_id_en(ifIdEn[1]),
        .if_id_flush(ifIdFlush[1]), .id_exe_en(idExeEn[1]), .id_exe_bubble(idExeBubble[1]),
        .exe_mem_en(exeMemEn[1]), .state(st[1]), .stall_cnt(stallB), .flush_cnt(flushB)
    );

    pipe_hazard_ctrl #(.LOAD_STALL(1), .CNT_W(4)) dutC (
        .clk(clk), .rst(rst), .id_rs(idRs), .id_rt(idRt), .id_use_rs(idUseRs), .id_use_rt(idUseRt),
        .exe_memRd(exeMemRd), .exe_regWr(exeRegWr), .exe_rd(exeRd), .br_taken(brTaken),
        .mem_busy(memBusy), .cnt_clr(cntClr), .pc_en(pcEn[2]), .if_id_en(ifIdEn[2]),
        .if_id_flush(ifIdFlush[2]), .id_exe_en(idExeEn[2]), .id_exe_bubble(idExeBubble[2]),
        .exe_mem_en(exeMemEn[2]), .state(st[2]), .stall_cnt(stallC), .flush_cnt(flushC)
    );

    function automatic logic [15:0] observe(int kind, int sel);
        logic [15:0] r;
        r = 16'hDEAD;
        if (kind == K_OUT) begin
            r = {8'h00, st[sel], pcEn[sel], ifIdEn[sel], ifIdFlush[sel],
                 idExeEn[sel], idExeBubble[sel], exeMemEn[sel]};
        end else if (kind == K_STALL) begin
            r = (sel == 0) ? stallA : (sel == 1) ? stallB : {12'h000, stallC};
        end else begin
            r = (sel == 0) ? flushA : (sel == 1) ? flushB : {12'h000, flushC};
        end
        return r;
    endfunction

    task automatic expOut(input string tag, input int sel, input logic [1:0] s, input logic [5:0] v);
        sb.push_back('{tag: tag, kind: K_OUT, sel: sel, val: {8'h00, s, v}});
    endtask

    task automatic expStall(input string tag, input int sel, input logic [15:0] v);
        sb.push_back('{tag: tag, kind: K_STALL, sel: sel, val: v});
    endtask

    task automatic expFlush(input string tag, input int sel, input logic [15:0] v);
        sb.push_back('{tag: tag, kind: K_FLUSH, sel: sel, val: v});
    endtask

    task automatic applyStimulus(input logic memRd, regWr, input logic [2:0] rd, rs, rt,
                                 input logic useRs, useRt, br, busy, clr);
        exeMemRd = memRd;
        exeRegWr = regWr;
        exeRd    = rd;
        idRs     = rs;
        idRt     = rt;
        idUseRs  = useRs;
        idUseRt  = useRt;
        brTaken  = br;
        memBusy  = busy;
        cntClr   = clr;
    endtask

    task automatic idle();
        applyStimulus(0, 0, 3'd0, 3'd0, 3'd0, 0, 0, 0, 0, 0);
    endtask

    task automatic hazard();
        applyStimulus(1, 1, 3'd3, 3'd3, 3'd0, 1, 0, 0, 0, 0);
    endtask

    task automatic checkOutput();
        exp_t e;
        logic [15:0] obs;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            obs = observe(e.kind, e.sel);
            total++;
            assert (obs === e.val) else begin
                bad++;
                $error("[TB] FAIL %s observed=%0h expected=%0h", e.tag, obs, e.val);
            end
        end
    endtask

    // Check mid-cycle, then move to just after the next rising edge.
    task automatic cyc();
        #4;
        checkOutput();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        idle();
        rst = 1'b1;
        @(posedge clk);
        #1;
        expOut("rstA", 0, 2'd0, FRZ);
        expOut("rstB", 1, 2'd0, FRZ);
        expStall("rstStallA", 0, 0);
        expFlush("rstFlushA", 0, 0);
        cyc();
        rst = 1'b0;

        // load-use, LOAD_STALL=1 (A) and LOAD_STALL=3 (B)
        expOut("idleA", 0, 2'd0, NORM);
        cyc();
        hazard();
        expOut("luA", 0, 2'd0, STALL);
        expOut("luB0", 1, 2'd0, STALL);
        cyc();
        idle();
        expOut("luAdone", 0, 2'd0, NORM);
        expStall("luAcnt", 0, 1);
        expOut("luB1", 1, 2'd1, STALL);
        expStall("luBcnt1", 1, 1);
        cyc();
        expOut("luB2", 1, 2'd1, STALL);
        cyc();
        expOut("luBdone", 1, 2'd0, NORM);
        expStall("luBcnt", 1, 3);
        cyc();
        cntClr = 1'b1;
        expOut("clrA", 0, 2'd0, NORM);
        cyc();
        cntClr = 1'b0;
        expStall("clrStallA", 0, 0);
        expStall("clrStallB", 1, 0);
        expStall("clrStallC", 2, 0);
        cyc();

        // branch in the 2nd cycle of a 3-cycle stall
        hazard();
        expOut("brB0", 1, 2'd0, STALL);
        cyc();
        applyStimulus(0, 0, 3'd0, 3'd0, 3'd0, 0, 0, 1, 0, 0);
        expOut("brB1", 1, 2'd1, FLUSH);
        expOut("brA", 0, 2'd0, FLUSH);
        cyc();
        idle();
        expOut("brBafter", 1, 2'd0, NORM);
        expFlush("brBfcnt", 1, 1);
        expStall("brBscnt", 1, 1);
        cyc();
        cntClr = 1'b1;
        cyc();
        cntClr = 1'b0;

        // memory wait with a branch arriving during the freeze
        applyStimulus(0, 0, 3'd0, 3'd0, 3'd0, 0, 0, 0, 1, 0);
        expOut("mw1", 0, 2'd0, FRZ);
        cyc();
        applyStimulus(0, 0, 3'd0, 3'd0, 3'd0, 0, 0, 1, 1, 0);
        expOut("mw2", 0, 2'd2, FRZ);
        cyc();
        applyStimulus(0, 0, 3'd0, 3'd0, 3'd0, 0, 0, 0, 1, 0);
        expOut("mw3", 0, 2'd2, FRZ);
        cyc();
        expOut("mw4", 0, 2'd2, FRZ);
        cyc();
        idle();
        expOut("mwFlush", 0, 2'd2, FLUSH);
        expStall("mwScnt", 0, 4);
        cyc();
        expOut("mwAfter", 0, 2'd0, NORM);
        expFlush("mwFcnt", 0, 1);
        expStall("mwScnt2", 0, 4);
        cyc();

        // memory wait interrupting a multi-cycle stall, then resuming it
        hazard();
        expOut("rsB0", 1, 2'd0, STALL);
        cyc();
        applyStimulus(0, 0, 3'd0, 3'd0, 3'd0, 0, 0, 0, 1, 0);
        expOut("rsB1", 1, 2'd1, FRZ);
        expOut("rsA1", 0, 2'd0, FRZ);
        cyc();
        idle();
        expOut("rsB2", 1, 2'd2, STALL);
        expOut("rsA2", 0, 2'd2, NORM);
        cyc();
        expOut("rsB3", 1, 2'd1, STALL);
        cyc();
        expOut("rsB4", 1, 2'd0, NORM);
        cyc();

        // register 0 is not exempt; non-matching and non-writing loads do not stall
        applyStimulus(1, 1, 3'd0, 3'd5, 3'd0, 0, 1, 0, 0, 0);
        expOut("r0A", 0, 2'd0, STALL);
        cyc();
        idle();
        cyc();
        cyc();
        applyStimulus(1, 1, 3'd3, 3'd2, 3'd3, 1, 0, 0, 0, 0);
        expOut("noMatchA", 0, 2'd0, NORM);
        expOut("noMatchB", 1, 2'd0, NORM);
        cyc();
        applyStimulus(1, 0, 3'd3, 3'd3, 3'd0, 1, 0, 0, 0, 0);
        expOut("noRegWrA", 0, 2'd0, NORM);
        cyc();
        idle();
        cyc();

        // async reset between edges while B is in LU_STALL
        hazard();
        expOut("arB0", 1, 2'd0, STALL);
        cyc();
        idle();
        expOut("arBpre", 1, 2'd1, STALL);
        #4;
        checkOutput();
        #2;
        rst = 1'b1;
        #1;
        expOut("arB", 1, 2'd0, FRZ);
        expStall("arBcnt", 1, 0);
        expStall("arAcnt", 0, 0);
        expFlush("arAfcnt", 0, 0);
        checkOutput();
        @(posedge clk);
        #1;
        rst = 1'b0;
        expOut("arBpost", 1, 2'd0, NORM);
        cyc();

        // saturation of a 4-bit counter, then clear together with an increment
        expStall("satC0", 2, 0);
        hazard();
        repeat (20) cyc();
        expStall("satC", 2, 15);
        cntClr = 1'b1;
        cyc();
        cntClr = 1'b0;
        expStall("satClrC", 2, 0);
        expStall("satClrA", 0, 0);
        idle();
        cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
